// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: one request/ack transaction per EX/MEM access,
// with store lane steering, byte enables, load extension, pipeline stall and ack timeout.
//   state | meaning
//   IDLE  | waiting for a legal, aligned access while the pipeline steps
//   BUSY  | request outstanding, waiting for ack or timeout
//   DONE  | access finished; wait for a step so the held instruction is not re-issued
module mem_access_unit #(
    parameter int NB           = 32,
    parameter int NB_SIZE_TYPE = 3,
    parameter int TIMEOUT      = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_step,
    input  logic                    i_halt,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic                    i_signed,
    input  logic [NB_SIZE_TYPE-1:0] i_word_size,
    input  logic [NB-1:0]           i_alu_result,
    input  logic [NB-1:0]           i_data_b,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [NB-1:0]           o_mem_addr,
    output logic [NB-1:0]           o_mem_wdata,
    output logic [3:0]              o_mem_be,
    input  logic                    i_mem_ack,
    input  logic [NB-1:0]           i_mem_rdata,
    output logic [NB-1:0]           o_load_data,
    output logic                    o_stall,
    output logic                    o_addr_error,
    output logic                    o_timeout
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [NB-1:0]   addr_q, addr_d;
    logic [NB-1:0]   wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [NB-1:0]   load_q, load_d;
    logic            timeout_q, timeout_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      lane_q, lane_d;
    logic            byte_q, byte_d;
    logic            half_q, half_d;
    logic            signed_q, signed_d;

    logic            access, legal, aligned, start;
    logic [NB-1:0]   st_wdata;
    logic [3:0]      st_be;
    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;
    logic [NB-1:0]   ext_data;

    assign access  = (state_q == IDLE) & i_step & ~i_halt & (i_mem_read | i_mem_write);
    assign legal   = $onehot(i_word_size);
    assign aligned = i_word_size[0]
                   | (i_word_size[1] & ~i_alu_result[0])
                   | (i_word_size[2] & (i_alu_result[1:0] == 2'b00));
    assign start        = access & legal & aligned;
    assign o_addr_error = access & ~(legal & aligned);
    assign o_stall      = start | (state_q == BUSY);

    always_comb begin
        st_wdata = i_data_b;
        st_be    = 4'b1111;
        if (i_word_size[0]) begin
            st_wdata = {4{i_data_b[7:0]}};
            st_be    = 4'b0001 << i_alu_result[1:0];
        end else if (i_word_size[1]) begin
            st_wdata = {2{i_data_b[15:0]}};
            st_be    = i_alu_result[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        lane_byte = i_mem_rdata[8*lane_q +: 8];
        lane_half = lane_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        ext_data  = i_mem_rdata;
        if (byte_q) begin
            ext_data = {{(NB-8){signed_q & lane_byte[7]}}, lane_byte};
        end else if (half_q) begin
            ext_data = {{(NB-16){signed_q & lane_half[15]}}, lane_half};
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        load_d    = load_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        byte_d    = byte_q;
        half_d    = half_q;
        signed_d  = signed_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = BUSY;
                    req_d    = 1'b1;
                    we_d     = i_mem_write;
                    addr_d   = {i_alu_result[NB-1:2], 2'b00};
                    wdata_d  = st_wdata;
                    be_d     = i_mem_write ? st_be : 4'b1111;
                    cnt_d    = '0;
                    lane_d   = i_alu_result[1:0];
                    byte_d   = i_word_size[0];
                    half_d   = i_word_size[1];
                    signed_d = i_signed;
                end
            end
            BUSY: begin
                if (i_mem_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) load_d = ext_data;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    req_d     = 1'b0;
                    load_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (i_step) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            load_q    <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            lane_q    <= '0;
            byte_q    <= 1'b0;
            half_q    <= 1'b0;
            signed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            load_q    <= load_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            byte_q    <= byte_d;
            half_q    <= half_d;
            signed_q  <= signed_d;
        end
    end

    assign o_mem_req   = req_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_be    = be_q;
    assign o_load_data = load_q;
    assign o_timeout   = timeout_q;
endmodule
